// File: rtl/adc_capture_packer.sv
// Captures XADC samples filtered by channel mask and decimation, packing each
// stored sample into a low byte and a tagged high byte written to dpram port A.
module adc_capture_packer #(
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned BYTE_W   = 8,
    parameter int unsigned ADDR     = 10,
    parameter int unsigned NCH      = 4,
    parameter int unsigned CH_BASE  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR-1:0]   n_samples,
    input  logic [NCH-1:0]    ch_mask,
    input  logic [7:0]        decim,
    input  logic              s_valid,
    input  logic [15:0]       s_data,
    input  logic [4:0]        s_chan,
    output logic              ram_we,
    output logic [ADDR-1:0]   ram_addr,
    output logic [BYTE_W-1:0] ram_din,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR-1:0]   count
);

    localparam int unsigned TAG_W = 16 - SAMPLE_W;
    localparam logic [ADDR-1:0] MAX_N = ADDR'(1) << (ADDR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    state_t              state, state_d;
    logic [ADDR-1:0]     n_q, n_d;
    logic [NCH-1:0]      mask_q, mask_d;
    logic [7:0]          decim_q, decim_d;
    logic [7:0]          dc, dc_d;
    logic [SAMPLE_W-1:0] smp_q, smp_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                ram_we_d, busy_d, done_d, overflow_d;
    logic [ADDR-1:0]     ram_addr_d, count_d;
    logic [BYTE_W-1:0]   ram_din_d;

    logic [4:0]          idx_c;
    logic                match_c;
    logic [ADDR-1:0]     eff_n_c, addr_inc_c, count_inc_c;
    logic [SAMPLE_W-1:0] smp_c;

    // Sample justification discards the XADC LSBs.
    logic unused_lsbs;
    assign unused_lsbs = ^s_data[15-SAMPLE_W:0];

    // Channel filter, length clamp and saturating address increment.
    always_comb begin
        idx_c   = s_chan - 5'(CH_BASE);
        match_c = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (s_valid && (idx_c == 5'(i)) && mask_q[i]) begin
                match_c = 1'b1;
            end
        end
        eff_n_c     = (n_samples > MAX_N) ? MAX_N : n_samples;
        addr_inc_c  = (ram_addr == '1) ? ram_addr : ram_addr + ADDR'(1);
        count_inc_c = count + ADDR'(1);
        smp_c       = s_data[15 -: SAMPLE_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            n_q      <= '0;
            mask_q   <= '0;
            decim_q  <= '0;
            dc       <= '0;
            smp_q    <= '0;
            tag_q    <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            count    <= '0;
        end else begin
            state    <= state_d;
            n_q      <= n_d;
            mask_q   <= mask_d;
            decim_q  <= decim_d;
            dc       <= dc_d;
            smp_q    <= smp_d;
            tag_q    <= tag_d;
            ram_we   <= ram_we_d;
            ram_addr <= ram_addr_d;
            ram_din  <= ram_din_d;
            busy     <= busy_d;
            done     <= done_d;
            overflow <= overflow_d;
            count    <= count_d;
        end
    end

    // Next state and next register values; outputs follow the state being entered.
    always_comb begin
        state_d    = state;
        n_d        = n_q;
        mask_d     = mask_q;
        decim_d    = decim_q;
        dc_d       = dc;
        smp_d      = smp_q;
        tag_d      = tag_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr;
        ram_din_d  = ram_din;
        overflow_d = overflow;
        count_d    = count;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        n_d        = eff_n_c;
                        mask_d     = ch_mask;
                        decim_d    = decim;
                        dc_d       = '0;
                        ram_addr_d = '0;
                        count_d    = '0;
                        overflow_d = 1'b0;
                        state_d    = (eff_n_c == '0) ? S_DONE : S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (match_c) begin
                        dc_d = (dc == decim_q) ? 8'd0 : dc + 8'd1;
                        // The first match after arming is stored, then every decim+1-th.
                        if (dc == 8'd0) begin
                            smp_d     = smp_c;
                            tag_d     = TAG_W'(idx_c);
                            ram_we_d  = 1'b1;
                            ram_din_d = BYTE_W'(smp_c[7:0]);
                            state_d   = S_WR_LO;
                        end
                    end
                end
                S_WR_LO: begin
                    if (match_c) overflow_d = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_din_d  = BYTE_W'({tag_q, smp_q[SAMPLE_W-1:8]});
                    ram_addr_d = addr_inc_c;
                    state_d    = S_WR_HI;
                end
                S_WR_HI: begin
                    if (match_c) overflow_d = 1'b1;
                    ram_addr_d = addr_inc_c;
                    count_d    = count_inc_c;
                    state_d    = (count_inc_c == n_q) ? S_DONE : S_ARMED;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_ARMED) || (state_d == S_WR_LO) || (state_d == S_WR_HI);
        done_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_adc_capture_packer.sv
// Randomised and directed bench for adc_capture_packer against a
// transaction-level model of stored samples and expected RAM writes.
`timescale 1ns/1ps
module tb_adc_capture_packer;

    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned ADDR     = 10;
    localparam int unsigned NCH      = 4;
    localparam int unsigned CH_BASE  = 3;

    logic              clk = 1'b0;
    logic              rst, start, abort, s_valid;
    logic [ADDR-1:0]   n_samples;
    logic [NCH-1:0]    ch_mask;
    logic [7:0]        decim;
    logic [15:0]       s_data;
    logic [4:0]        s_chan;
    logic              ram_we;
    logic [ADDR-1:0]   ram_addr;
    logic [BYTE_W-1:0] ram_din;
    logic              busy, done, overflow;
    logic [ADDR-1:0]   count;

    always #5 clk = ~clk;

    adc_capture_packer #(
        .SAMPLE_W(SAMPLE_W), .BYTE_W(BYTE_W), .ADDR(ADDR), .NCH(NCH), .CH_BASE(CH_BASE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .n_samples(n_samples), .ch_mask(ch_mask), .decim(decim),
        .s_valid(s_valid), .s_data(s_data), .s_chan(s_chan),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .busy(busy), .done(done), .overflow(overflow), .count(count)
    );

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t      exp_q[$];
    wr_t      mon_w;
    int       edge_n = 0;
    int       checks = 0;
    int       passes = 0;
    logic [7:0] sh [0:1023];

    // Model state: capture progress expressed as counts and edge numbers.
    int  m_eff, m_nmatch, m_decim, m_stored, m_block_end, m_fin_edge;
    bit  m_active, m_last, m_done, m_ovf, m_aborted;
    logic [NCH-1:0] m_mask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, expv, edge_n);
    endtask

    task automatic drop_from(input int ed);
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].cyc >= ed) exp_q.delete(i);
    endtask

    task automatic model_settle(input int upto);
        if (m_active && m_last && upto >= m_fin_edge) begin
            m_active = 0;
            m_last   = 0;
            m_done   = 1;
        end
    endtask

    function automatic bit is_match();
        int ch;
        ch = int'(s_chan);
        return s_valid && (ch >= int'(CH_BASE)) && (ch < int'(CH_BASE + NCH)) && m_mask[ch - int'(CH_BASE)];
    endfunction

    // Effect of the currently driven inputs at edge number ed.
    task automatic model_edge(input int ed);
        int smp, idx;
        model_settle(ed - 1);
        if (rst) begin
            drop_from(ed);
            m_active = 0; m_last = 0; m_done = 0; m_ovf = 0; m_stored = 0; m_aborted = 0;
        end else if (abort) begin
            drop_from(ed);
            if (m_active && ed <= m_block_end) m_stored--;
            m_active = 0; m_last = 0; m_done = 0; m_aborted = 1;
        end else if (start && !m_active) begin
            m_eff       = (int'(n_samples) > 512) ? 512 : int'(n_samples);
            m_mask      = ch_mask;
            m_decim     = int'(decim);
            m_nmatch    = 0;
            m_stored    = 0;
            m_ovf       = 0;
            m_block_end = -1;
            m_last      = 0;
            m_aborted   = 0;
            m_active    = (m_eff != 0);
            m_done      = (m_eff == 0);
        end else if (m_active && is_match()) begin
            if (ed <= m_block_end) begin
                m_ovf = 1;
            end else begin
                if (m_nmatch % (m_decim + 1) == 0) begin
                    smp = int'(s_data) >> 4;
                    idx = int'(s_chan) - int'(CH_BASE);
                    exp_q.push_back('{ed,     2 * m_stored,     smp & 255});
                    exp_q.push_back('{ed + 1, 2 * m_stored + 1, (idx << 4) | (smp >> 8)});
                    m_stored++;
                    m_block_end = ed + 2;
                    if (m_stored == m_eff) begin
                        m_last     = 1;
                        m_fin_edge = ed + 2;
                    end
                end
                m_nmatch++;
            end
        end
    endtask

    task automatic step(input bit st, input bit ab, input bit sv, input logic [15:0] sd, input logic [4:0] ch);
        start = st; abort = ab; s_valid = sv; s_data = sd; s_chan = ch;
        model_edge(edge_n + 1);
        @(posedge clk);
        edge_n++;
        #1;
        start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 5'd0);
    endtask

    task automatic send(input logic [15:0] sd, input logic [4:0] ch);
        step(0, 0, 1, sd, ch);
        idle(3);
    endtask

    task automatic check_status(input string tag);
        int exp_addr;
        idle(3);
        model_settle(edge_n);
        chk({tag, "_done"}, done, m_done);
        chk({tag, "_busy"}, busy, m_active);
        chk({tag, "_count"}, count, m_stored);
        chk({tag, "_overflow"}, overflow, m_ovf);
        if (!m_aborted) begin
            exp_addr = m_done ? ((2 * m_eff > 1023) ? 1023 : 2 * m_eff) : 2 * m_stored;
            chk({tag, "_ram_addr"}, ram_addr, exp_addr);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_din"}, ram_din, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_count"}, count, 0);
    endtask

    // Every cycle: each RAM write must match the next expected write exactly.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            sh[ram_addr] = ram_din;
            if (exp_q.size() == 0) begin
                chk("write_unexpected", ram_we, 0);
            end else begin
                mon_w = exp_q.pop_front();
                chk("wr_cycle", edge_n, mon_w.cyc);
                chk("wr_addr", ram_addr, mon_w.addr);
                chk("wr_data", ram_din, mon_w.data);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
            mon_w = exp_q.pop_front();
            chk("write_expected", ram_we, 1);
        end
    end

    logic [7:0]  t1_bytes [6];
    logic [15:0] last_d;
    logic [15:0] d;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        s_data = '0; s_chan = '0; n_samples = '0; ch_mask = '0; decim = '0;
        m_active = 0; m_last = 0; m_done = 0; m_ovf = 0; m_aborted = 0;
        m_stored = 0; m_eff = 0; m_block_end = -1; m_fin_edge = 0; m_mask = '0;
        m_nmatch = 0; m_decim = 0;
        idle(2);
        rst = 1'b0;
        check_reset_vals("reset");

        // Three samples on ch3, one byte pair each.
        ch_mask = 4'b0001; decim = 8'd0; n_samples = 10'd3;
        step(1, 0, 0, 16'h0, 5'd0);
        send(16'hABC0, 5'd3);
        send(16'h1230, 5'd3);
        send(16'hFFF0, 5'd3);
        check_status("basic");
        t1_bytes = '{8'hBC, 8'h0A, 8'h23, 8'h01, 8'hFF, 8'h0F};
        for (int i = 0; i < 6; i++) chk($sformatf("basic_byte%0d", i), sh[i], t1_bytes[i]);
        chk("basic_done_lit", done, 1);
        chk("basic_count_lit", count, 3);
        chk("basic_addr_lit", ram_addr, 6);

        // Mask 0101: channels 3 and 5 stored, ch5 high byte tagged 2.
        ch_mask = 4'b0101; n_samples = 10'd2;
        step(1, 0, 0, 16'h0, 5'd0);
        chk("rearm_addr_lit", ram_addr, 0);
        send(16'h1110, 5'd3);
        send(16'h2220, 5'd4);
        send(16'h3330, 5'd5);
        send(16'h4440, 5'd6);
        check_status("mask");
        chk("mask_lo5_lit", sh[2], 8'h33);
        chk("mask_tag5_lit", 32'(sh[3] >> 4), 2);
        chk("mask_hi5_lit", sh[3], 8'h23);

        // decim=2: matches 0 and 3 of 7 stored.
        ch_mask = 4'b0001; decim = 8'd2; n_samples = 10'd2;
        step(1, 0, 0, 16'h0, 5'd0);
        for (int k = 0; k < 7; k++) begin
            d = {4'(k + 1), 4'(k + 1), 4'(k + 1), 4'h0};
            send(d, 5'd3);
        end
        check_status("decim");
        chk("decim_b0_lit", sh[0], 8'h11);
        chk("decim_b1_lit", sh[1], 8'h01);
        chk("decim_b2_lit", sh[2], 8'h44);
        chk("decim_b3_lit", sh[3], 8'h04);

        // Back-to-back strobes: second one dropped, overflow sticky.
        decim = 8'd0; n_samples = 10'd2;
        step(1, 0, 0, 16'h0, 5'd0);
        step(0, 0, 1, 16'h5550, 5'd3);
        step(0, 0, 1, 16'h6660, 5'd3);
        idle(3);
        send(16'h7770, 5'd3);
        check_status("ovf");
        chk("ovf_lit", overflow, 1);
        chk("ovf_b2_lit", sh[2], 8'h77);
        step(1, 0, 0, 16'h0, 5'd0);
        chk("ovf_clear_lit", overflow, 0);
        chk("ovf_rearm_addr_lit", ram_addr, 0);
        chk("ovf_rearm_busy_lit", busy, 1);

        // Abort after one stored sample.
        send(16'h8880, 5'd3);
        step(0, 1, 0, 16'h0, 5'd0);
        chk("abort_done_lit", done, 0);
        chk("abort_busy_lit", busy, 0);
        chk("abort_count_lit", count, 1);
        check_status("abort");

        // Zero length: done the cycle after start, no writes.
        n_samples = 10'd0;
        step(1, 0, 0, 16'h0, 5'd0);
        chk("zero_done_lit", done, 1);
        chk("zero_busy_lit", busy, 0);
        step(0, 0, 1, 16'h9990, 5'd3);
        check_status("zero");

        // Oversized request clamps to 512 samples ending at address 1023.
        n_samples = 10'd1023;
        step(1, 0, 0, 16'h0, 5'd0);
        last_d = '0;
        for (int k = 0; k < 512; k++) begin
            last_d = 16'($urandom);
            step(0, 0, 1, last_d, 5'd3);
            idle(2);
        end
        check_status("full");
        chk("full_count_lit", count, 512);
        chk("full_addr_lit", ram_addr, 1023);
        chk("full_lo_last", sh[1022], last_d[11:4]);
        chk("full_hi_last", sh[1023], {4'h0, last_d[15:12]});

        // Reset while the low byte is being written.
        n_samples = 10'd2;
        step(1, 0, 0, 16'h0, 5'd0);
        step(0, 0, 1, 16'h5A50, 5'd3);
        rst = 1'b1;
        step(0, 0, 0, 16'h0, 5'd0);
        rst = 1'b0;
        check_reset_vals("rst_wrlo");
        chk("rst_wrlo_byte_lit", sh[0], 8'hA5);
        check_status("post_rst");

        // Random configurations and traffic.
        for (int r = 0; r < 20; r++) begin
            n_samples = 10'($urandom_range(1, 6));
            ch_mask   = 4'($urandom_range(1, 15));
            decim     = 8'($urandom_range(0, 3));
            step(0, 1, 0, 16'h0, 5'd0);
            step(1, 0, 0, 16'h0, 5'd0);
            for (int c = 0; c < 60; c++) begin
                step(($urandom_range(0, 30) == 0), ($urandom_range(0, 80) == 0),
                     1'($urandom_range(0, 1)), 16'($urandom), 5'($urandom_range(0, 9)));
            end
            check_status($sformatf("rand%0d", r));
        end

        idle(2);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
